// File: rtl/timer_pkg.sv
// Shared definitions for the countdown timer: FSM state encoding and the
// default prescaler ratio for a 1 s base tick from a 50 MHz clock.
package timer_pkg;

  // Two-bit state encoding of the countdown FSM.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    PAUSED  = 2'd2,
    EXPIRED = 2'd3
  } state_t;

  // 50 MHz clock divided down to a 1 s base tick.
  localparam int unsigned DEFAULT_TICK_DIV = 50_000_000;

endpackage

// File: rtl/tick_prescaler.sv
// Base-tick prescaler: counts enabled clk cycles and flags the last cycle of
// each DIV-cycle period. The tick is combinational so the FSM can act on it
// in the same cycle; clr has priority over en and forces the count to zero.
module tick_prescaler #(
  parameter int unsigned DIV = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(DIV - 1);

  logic [PW-1:0] count_r;

  assign tick = en & (count_r == LAST);

  // Prescaler count: clear, wrap on the last cycle, or advance while enabled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_r <= {PW{1'b0}};
    end else if (clr) begin
      count_r <= {PW{1'b0}};
    end else if (en) begin
      if (count_r == LAST) begin
        count_r <= {PW{1'b0}};
      end else begin
        count_r <= count_r + PW'(1);
      end
    end else begin
      count_r <= count_r;
    end
  end

endmodule

// File: rtl/countdown_timer_fsm.sv
// Programmable countdown timer for game timing (round clock, power-up
// duration, periodic pacing). Counts load_val base ticks down to zero with
// pause/resume, abort and one-shot or auto-reload behaviour.
// Optional feature macro: COUNTDOWN_WARN_EN adds a registered low-time warn
// flag; without it warn is tied low.
module countdown_timer_fsm
  import timer_pkg::*;
#(
  parameter int unsigned TICK_DIV   = DEFAULT_TICK_DIV,
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned WARN_LEVEL = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic             resume,
  input  logic             auto_reload,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] remaining,
  output logic             busy,
  output logic             paused,
  output logic             expire_tick,
  output logic             warn
);

  localparam logic [CNT_W-1:0] ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  state_t           state_r;
  state_t           state_nxt_s;
  state_t           load_state_s;
  logic [CNT_W-1:0] remaining_r;
  logic [CNT_W-1:0] rem_nxt_s;
  logic             tick_s;
  logic             en_s;
  logic             clr_s;

  // A WARN_LEVEL of zero means the warning can never assert.
  if (WARN_LEVEL == 0) begin : g_warn_never_fires
  end

  // The prescaler only runs in RUNNING cycles that take no command; it is
  // cleared whenever the count is (re)loaded, aborted or parked.
  assign en_s  = (state_r == RUNNING) & ~stop & ~start & ~pause;
  assign clr_s = (state_r == IDLE) | (state_r == EXPIRED) | start | stop;

  // Loading zero expires immediately instead of running.
  assign load_state_s = (load_val == ZERO) ? EXPIRED : RUNNING;

  tick_prescaler #(
    .DIV (TICK_DIV)
  ) u_prescaler (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (en_s),
    .clr     (clr_s),
    .tick    (tick_s)
  );

  // Next-state and next-count logic; command priority stop > start > pause > resume.
  always_comb begin
    state_nxt_s = state_r;
    rem_nxt_s   = remaining_r;
    case (state_r)
      IDLE: begin
        if (stop) begin
          state_nxt_s = IDLE;
          rem_nxt_s   = ZERO;
        end else if (start) begin
          state_nxt_s = load_state_s;
          rem_nxt_s   = load_val;
        end else begin
          state_nxt_s = IDLE;
          rem_nxt_s   = ZERO;
        end
      end
      RUNNING: begin
        if (stop) begin
          state_nxt_s = IDLE;
          rem_nxt_s   = ZERO;
        end else if (start) begin
          state_nxt_s = load_state_s;
          rem_nxt_s   = load_val;
        end else if (pause) begin
          state_nxt_s = PAUSED;
          rem_nxt_s   = remaining_r;
        end else if (tick_s) begin
          if (remaining_r <= ONE) begin
            state_nxt_s = EXPIRED;
            rem_nxt_s   = ZERO;
          end else begin
            state_nxt_s = RUNNING;
            rem_nxt_s   = remaining_r - ONE;
          end
        end else begin
          state_nxt_s = RUNNING;
          rem_nxt_s   = remaining_r;
        end
      end
      PAUSED: begin
        if (stop) begin
          state_nxt_s = IDLE;
          rem_nxt_s   = ZERO;
        end else if (start) begin
          state_nxt_s = load_state_s;
          rem_nxt_s   = load_val;
        end else if (resume) begin
          state_nxt_s = RUNNING;
          rem_nxt_s   = remaining_r;
        end else begin
          state_nxt_s = PAUSED;
          rem_nxt_s   = remaining_r;
        end
      end
      EXPIRED: begin
        if (stop) begin
          state_nxt_s = IDLE;
          rem_nxt_s   = ZERO;
        end else if (start | auto_reload) begin
          state_nxt_s = load_state_s;
          rem_nxt_s   = load_val;
        end else begin
          state_nxt_s = IDLE;
          rem_nxt_s   = ZERO;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        rem_nxt_s   = ZERO;
      end
    endcase
  end

  // State and remaining-count registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= IDLE;
      remaining_r <= ZERO;
    end else begin
      state_r     <= state_nxt_s;
      remaining_r <= rem_nxt_s;
    end
  end

  assign remaining   = remaining_r;
  assign busy        = (state_r != IDLE);
  assign paused      = (state_r == PAUSED);
  assign expire_tick = (state_r == EXPIRED);

`ifdef COUNTDOWN_WARN_EN
  localparam logic [CNT_W-1:0] WARN_THR = CNT_W'(WARN_LEVEL);

  logic warn_r;
  logic warn_nxt_s;

  // Warning follows the next count while running, freezes while paused.
  always_comb begin
    warn_nxt_s = 1'b0;
    case (state_nxt_s)
      RUNNING: warn_nxt_s = (rem_nxt_s != ZERO) && (rem_nxt_s <= WARN_THR);
      PAUSED:  warn_nxt_s = warn_r;
      default: warn_nxt_s = 1'b0;
    endcase
  end

  // Registered warning flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      warn_r <= 1'b0;
    end else begin
      warn_r <= warn_nxt_s;
    end
  end

  assign warn = warn_r;
`else
  assign warn = 1'b0;
`endif

endmodule

// File: tb/tb_countdown_timer_fsm.sv
// Directed self-checking bench for countdown_timer_fsm with TICK_DIV=4,
// CNT_W=8, WARN_LEVEL=2. Inputs change 1 time unit after a rising edge and
// outputs are sampled at that same point, so "past En" means the values
// registered at edge En. Warn expectations follow COUNTDOWN_WARN_EN.
module tb_countdown_timer_fsm;

`ifdef COUNTDOWN_WARN_EN
  localparam bit WARN_ON = 1'b1;
`else
  localparam bit WARN_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       pause = 1'b0;
  logic       resume = 1'b0;
  logic       auto_reload = 1'b0;
  logic [7:0] load_val = 8'd0;
  logic [7:0] remaining;
  logic       busy;
  logic       paused;
  logic       expire_tick;
  logic       warn;

  int n_checks = 0;
  int n_fail   = 0;

  countdown_timer_fsm #(
    .TICK_DIV   (4),
    .CNT_W      (8),
    .WARN_LEVEL (2)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .stop        (stop),
    .pause       (pause),
    .resume      (resume),
    .auto_reload (auto_reload),
    .load_val    (load_val),
    .remaining   (remaining),
    .busy        (busy),
    .paused      (paused),
    .expire_tick (expire_tick),
    .warn        (warn)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, limit 200000", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Start pulse sampled at the next edge (E0); returns just past E0.
  task automatic pulse_start(input logic [7:0] v);
    load_val = v;
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic test_reset;
    #1;
    n_checks++; if (remaining !== 8'd0) begin n_fail++; $display("FAIL reset_rem: got %0d want 0", remaining); end
    n_checks++; if ({busy, paused, expire_tick, warn} !== 4'b0000) begin n_fail++; $display("FAIL reset_flags: got %b want 0000", {busy, paused, expire_tick, warn}); end
    step(2);
    reset_n = 1'b1;
    step(2);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_release_busy: got %b want 0", busy); end
  endtask

  task automatic test_basic;
    pulse_start(8'd3);
    n_checks++; if (remaining !== 8'd3 || busy !== 1'b1) begin n_fail++; $display("FAIL basic_e0: rem %0d busy %b want 3 1", remaining, busy); end
    step(3);
    n_checks++; if (remaining !== 8'd3) begin n_fail++; $display("FAIL basic_e3: got %0d want 3", remaining); end
    step(1);
    n_checks++; if (remaining !== 8'd2) begin n_fail++; $display("FAIL basic_e4: got %0d want 2", remaining); end
    step(4);
    n_checks++; if (remaining !== 8'd1) begin n_fail++; $display("FAIL basic_e8: got %0d want 1", remaining); end
    step(3);
    n_checks++; if (expire_tick !== 1'b0 || remaining !== 8'd1) begin n_fail++; $display("FAIL basic_e11: exp %b rem %0d want 0 1", expire_tick, remaining); end
    step(1);
    n_checks++; if (remaining !== 8'd0 || expire_tick !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL basic_e12: rem %0d exp %b busy %b want 0 1 1", remaining, expire_tick, busy); end
    step(1);
    n_checks++; if (expire_tick !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL basic_e13: exp %b busy %b want 0 0", expire_tick, busy); end
  endtask

  task automatic test_pause;
    pulse_start(8'd5);
    step(5);
    pause = 1'b1;
    step(1);
    pause = 1'b0;
    // past E6: paused, count frozen at 4
    for (int e = 6; e < 15; e++) begin
      n_checks++; if (paused !== 1'b1 || remaining !== 8'd4 || busy !== 1'b1) begin n_fail++; $display("FAIL pause_hold_e%0d: paused %b rem %0d busy %b want 1 4 1", e, paused, remaining, busy); end
      if (e == 14) resume = 1'b1;
      step(1);
    end
    resume = 1'b0;
    n_checks++; if (paused !== 1'b0 || remaining !== 8'd4) begin n_fail++; $display("FAIL pause_resume_e15: paused %b rem %0d want 0 4", paused, remaining); end
    step(2);
    n_checks++; if (remaining !== 8'd4) begin n_fail++; $display("FAIL pause_e17: got %0d want 4", remaining); end
    step(1);
    n_checks++; if (remaining !== 8'd3) begin n_fail++; $display("FAIL pause_e18: got %0d want 3", remaining); end
    step(2);
    n_checks++; if (expire_tick !== 1'b0) begin n_fail++; $display("FAIL pause_no_early_exp_e20: got %b want 0", expire_tick); end
    step(9);
    n_checks++; if (expire_tick !== 1'b0 || remaining !== 8'd1) begin n_fail++; $display("FAIL pause_e29: exp %b rem %0d want 0 1", expire_tick, remaining); end
    step(1);
    n_checks++; if (expire_tick !== 1'b1 || remaining !== 8'd0) begin n_fail++; $display("FAIL pause_e30: exp %b rem %0d want 1 0", expire_tick, remaining); end
    step(1);
  endtask

  task automatic test_auto_reload;
    int pulses;
    auto_reload = 1'b1;
    pulse_start(8'd2);
    step(8);
    n_checks++; if (expire_tick !== 1'b1) begin n_fail++; $display("FAIL reload_e8: got %b want 1", expire_tick); end
    step(1);
    n_checks++; if (expire_tick !== 1'b0 || remaining !== 8'd2 || busy !== 1'b1) begin n_fail++; $display("FAIL reload_e9: exp %b rem %0d busy %b want 0 2 1", expire_tick, remaining, busy); end
    step(7);
    n_checks++; if (expire_tick !== 1'b0) begin n_fail++; $display("FAIL reload_e16: got %b want 0", expire_tick); end
    step(1);
    n_checks++; if (expire_tick !== 1'b1) begin n_fail++; $display("FAIL reload_e17: got %b want 1", expire_tick); end
    step(9);
    n_checks++; if (expire_tick !== 1'b1) begin n_fail++; $display("FAIL reload_e26: got %b want 1", expire_tick); end
    step(2);
    stop = 1'b1;
    step(1);
    stop = 1'b0;
    auto_reload = 1'b0;
    n_checks++; if (busy !== 1'b0 || remaining !== 8'd0 || expire_tick !== 1'b0) begin n_fail++; $display("FAIL reload_stop: busy %b rem %0d exp %b want 0 0 0", busy, remaining, expire_tick); end
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      step(1);
      if (expire_tick === 1'b1) pulses++;
    end
    n_checks++; if (pulses != 0) begin n_fail++; $display("FAIL reload_after_stop_pulses: got %0d want 0", pulses); end
  endtask

  task automatic test_load_zero;
    pulse_start(8'd0);
    n_checks++; if (expire_tick !== 1'b1 || remaining !== 8'd0 || busy !== 1'b1) begin n_fail++; $display("FAIL zero_e0: exp %b rem %0d busy %b want 1 0 1", expire_tick, remaining, busy); end
    step(1);
    n_checks++; if (expire_tick !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL zero_e1: exp %b busy %b want 0 0", expire_tick, busy); end
  endtask

  task automatic test_restart;
    pulse_start(8'd3);
    step(11);
    n_checks++; if (remaining !== 8'd1) begin n_fail++; $display("FAIL restart_e11: got %0d want 1", remaining); end
    load_val = 8'd3;
    start = 1'b1;
    step(1);
    start = 1'b0;
    n_checks++; if (remaining !== 8'd3 || expire_tick !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL restart_e12: rem %0d exp %b busy %b want 3 0 1", remaining, expire_tick, busy); end
    step(3);
    n_checks++; if (remaining !== 8'd3 || expire_tick !== 1'b0) begin n_fail++; $display("FAIL restart_e15: rem %0d exp %b want 3 0", remaining, expire_tick); end
    step(1);
    n_checks++; if (remaining !== 8'd2) begin n_fail++; $display("FAIL restart_e16: got %0d want 2", remaining); end
    stop = 1'b1;
    step(1);
    stop = 1'b0;
  endtask

  task automatic test_start_stop;
    load_val = 8'd3;
    start = 1'b1;
    stop = 1'b1;
    step(1);
    n_checks++; if (busy !== 1'b0 || remaining !== 8'd0) begin n_fail++; $display("FAIL startstop_idle: busy %b rem %0d want 0 0", busy, remaining); end
    stop = 1'b0;
    step(1);
    start = 1'b0;
    step(2);
    start = 1'b1;
    stop = 1'b1;
    step(1);
    start = 1'b0;
    stop = 1'b0;
    n_checks++; if (busy !== 1'b0 || remaining !== 8'd0 || expire_tick !== 1'b0) begin n_fail++; $display("FAIL startstop_running: busy %b rem %0d exp %b want 0 0 0", busy, remaining, expire_tick); end
  endtask

  task automatic test_reset_mid;
    pulse_start(8'd3);
    step(4);
    n_checks++; if (remaining !== 8'd2) begin n_fail++; $display("FAIL rstmid_pre: got %0d want 2", remaining); end
    #2;
    reset_n = 1'b0;
    #1;
    n_checks++; if (remaining !== 8'd0 || {busy, paused, expire_tick, warn} !== 4'b0000) begin n_fail++; $display("FAIL rstmid_async: rem %0d flags %b want 0 0000", remaining, {busy, paused, expire_tick, warn}); end
    step(2);
    reset_n = 1'b1;
    step(5);
    n_checks++; if (busy !== 1'b0 || remaining !== 8'd0) begin n_fail++; $display("FAIL rstmid_release: busy %b rem %0d want 0 0", busy, remaining); end
    pulse_start(8'd1);
    n_checks++; if (remaining !== 8'd1 || busy !== 1'b1) begin n_fail++; $display("FAIL rstmid_restart: rem %0d busy %b want 1 1", remaining, busy); end
    step(4);
    n_checks++; if (expire_tick !== 1'b1) begin n_fail++; $display("FAIL rstmid_expire: got %b want 1", expire_tick); end
    step(1);
  endtask

  task automatic test_warn;
    pulse_start(8'd4);
    n_checks++; if (warn !== 1'b0) begin n_fail++; $display("FAIL warn_rem4: got %b want 0", warn); end
    step(4);
    n_checks++; if (warn !== 1'b0 || remaining !== 8'd3) begin n_fail++; $display("FAIL warn_rem3: warn %b rem %0d want 0 3", warn, remaining); end
    step(4);
    n_checks++; if (warn !== WARN_ON || remaining !== 8'd2) begin n_fail++; $display("FAIL warn_rem2: warn %b rem %0d want %b 2", warn, remaining, WARN_ON); end
    step(4);
    n_checks++; if (warn !== WARN_ON || remaining !== 8'd1) begin n_fail++; $display("FAIL warn_rem1: warn %b rem %0d want %b 1", warn, remaining, WARN_ON); end
    step(4);
    n_checks++; if (warn !== 1'b0 || expire_tick !== 1'b1) begin n_fail++; $display("FAIL warn_expire: warn %b exp %b want 0 1", warn, expire_tick); end
    step(1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_pause();
    test_auto_reload();
    test_load_zero();
    test_restart();
    test_start_stop();
    test_reset_mid();
    test_warn();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
